// File: rtl/truncador_pwm_gen_pkg.sv
// Shared defaults and the saturation-range helper used by the sample datapath.
package truncador_pkg;

  localparam int DEF_W_IN     = 28;
  localparam int DEF_LSB_DROP = 4;
  localparam int DEF_N_OUT    = 11;
  localparam int DEF_ROUND    = 0;
  localparam int DEF_W_SATCNT = 8;

  localparam int PERIOD   = 2**DEF_N_OUT - 1;
  localparam int MID_CODE = 2**(DEF_N_OUT - 1);

  typedef struct packed {
    logic pos;
    logic neg;
  } sat_flags_t;

  // v is the sign-extended (and optionally rounded) sample; the kept field fits
  // iff everything from its sign bit upward is a pure sign extension.
  function automatic sat_flags_t sat_trunc(input logic [63:0] v, input int lsb_drop,
                                           input int n_out);
    sat_flags_t r;
    logic [63:0] hi;
    hi = $signed(v) >>> (lsb_drop + n_out - 1);
    r  = '0;
    if (hi != '0 && hi != '1) begin
      if (v[63]) r.neg = 1'b1;
      else       r.pos = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/truncador_pwm_gen_pwm_core.sv
// PWM counter with shadow-to-active duty transfer only at period wrap or while disabled.
module pwm_core
  import truncador_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_OUT-1:0] shadow_duty,
  output logic             pwm_out,
  output logic             period_start
);

  localparam logic [N_OUT-1:0] CNT_MAX = {{(N_OUT-1){1'b1}}, 1'b0};
  localparam logic [N_OUT-1:0] MID     = {1'b1, {(N_OUT-1){1'b0}}};

  logic [N_OUT-1:0] cnt;
  logic [N_OUT-1:0] active_duty;

  // pwm_out and period_start are registered from the same cnt, so they stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      active_duty  <= MID;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else if (!enable) begin
      cnt          <= '0;
      active_duty  <= shadow_duty;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= (cnt < active_duty);
      period_start <= (cnt == '0);
      if (cnt == CNT_MAX) begin
        cnt         <= '0;
        active_duty <= shadow_duty;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/truncador_pwm_gen.sv
// Sample capture, truncate/round + saturate to offset-binary duty, statistics, PWM.
module truncador_pwm_gen
  import truncador_pkg::*;
#(
  parameter int W_IN     = DEF_W_IN,
  parameter int LSB_DROP = DEF_LSB_DROP,
  parameter int N_OUT    = DEF_N_OUT,
  parameter int ROUND    = DEF_ROUND,
  parameter int W_SATCNT = DEF_W_SATCNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                CS,
  input  logic [W_IN-1:0]     Dato_In,
  input  logic                enable,
  input  logic                clr_sat,
  output logic [N_OUT-1:0]    Dato_Out,
  output logic                dato_valid,
  output logic                sat_pos,
  output logic                sat_neg,
  output logic [W_SATCNT-1:0] sat_count,
  output logic                pwm_out,
  output logic                period_start
);

  localparam logic [N_OUT-1:0] MID = {1'b1, {(N_OUT-1){1'b0}}};

  logic             cs_s1, cs_s2, strobe, cap_v;
  logic [W_IN-1:0]  data_r;
  logic [63:0]      v_ext;
  sat_flags_t       flags;
  logic [N_OUT-1:0] code_w;

  assign strobe = cs_s1 & ~cs_s2;

  // 64-bit working width: the rounding add can never wrap.
  always_comb begin
    v_ext = {{(64-W_IN){data_r[W_IN-1]}}, data_r};
    if (ROUND != 0 && LSB_DROP > 0) v_ext = v_ext + (64'd1 << (LSB_DROP - 1));
    flags = sat_trunc(v_ext, LSB_DROP, N_OUT);
    if (flags.pos)      code_w = '1;
    else if (flags.neg) code_w = '0;
    else                code_w = {~v_ext[LSB_DROP+N_OUT-1], v_ext[LSB_DROP+N_OUT-2:LSB_DROP]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s1      <= 1'b0;
      cs_s2      <= 1'b0;
      cap_v      <= 1'b0;
      data_r     <= '0;
      Dato_Out   <= MID;
      dato_valid <= 1'b0;
      sat_pos    <= 1'b0;
      sat_neg    <= 1'b0;
      sat_count  <= '0;
    end else begin
      cs_s1      <= CS;
      cs_s2      <= cs_s1;
      cap_v      <= strobe;
      dato_valid <= cap_v;
      if (strobe) data_r <= Dato_In;
      if (cap_v) begin
        Dato_Out <= code_w;
        sat_pos  <= flags.pos;
        sat_neg  <= flags.neg;
      end
      if (clr_sat)
        sat_count <= '0;
      else if (cap_v && (flags.pos || flags.neg) && sat_count != '1)
        sat_count <= sat_count + 1'b1;
    end
  end

  // Dato_Out doubles as the shadow duty register feeding the PWM.
  pwm_core #(.N_OUT(N_OUT)) u_pwm (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .shadow_duty  (Dato_Out),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

endmodule

// File: tb/tb_truncador_pwm_gen.sv
// Directed bench: truncating and rounding instances side by side, plus PWM sequences.
module tb_truncador_pwm_gen;

  logic        clk = 1'b0;
  logic        reset, CS, enable, clr_sat;
  logic [27:0] Dato_In;

  logic [10:0] t_dout, r_dout;
  logic        t_dv, t_pos, t_neg, t_pwm, t_ps;
  logic        r_dv, r_pos, r_neg, r_pwm, r_ps;
  logic [7:0]  t_cnt, r_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  truncador_pwm_gen dut_t (
    .clk(clk), .reset(reset), .CS(CS), .Dato_In(Dato_In), .enable(enable), .clr_sat(clr_sat),
    .Dato_Out(t_dout), .dato_valid(t_dv), .sat_pos(t_pos), .sat_neg(t_neg), .sat_count(t_cnt),
    .pwm_out(t_pwm), .period_start(t_ps)
  );

  truncador_pwm_gen #(.ROUND(1)) dut_r (
    .clk(clk), .reset(reset), .CS(CS), .Dato_In(Dato_In), .enable(enable), .clr_sat(clr_sat),
    .Dato_Out(r_dout), .dato_valid(r_dv), .sat_pos(r_pos), .sat_neg(r_neg), .sat_count(r_cnt),
    .pwm_out(r_pwm), .period_start(r_ps)
  );

  typedef struct {
    logic [27:0] din;
    logic [10:0] t_code;
    logic        t_p;
    logic        t_n;
    logic [10:0] r_code;
    logic        r_p;
    logic        r_n;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive_sample(input logic [27:0] din);
    @(negedge clk);
    Dato_In = din;
    CS = 1'b1;
    @(negedge clk);
    CS = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Returns at the first negedge showing period_start; cyc = negedges waited.
  task automatic wait_ps(output int cyc);
    int found;
    found = 0;
    cyc = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      cyc++;
      if (t_ps) found = 1;
    end
    check("ps_timeout", 0, found, 1);
  endtask

  task automatic measure(input int n, output int hi, output int starts, output int bad_gap);
    int last;
    hi = 0; starts = 0; bad_gap = 0; last = -1;
    for (int i = 0; i < n; i++) begin
      if (t_pwm) hi++;
      if (t_ps) begin
        starts++;
        if (last >= 0 && i - last != 2047) bad_gap++;
        last = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, found, cyc, hi, starts, bad, hi1, hi2, bad1, bad2, ps_bad, dv_sum;

    vecs[0]  = '{28'h0000000, 11'd1024, 1'b0, 1'b0, 11'd1024, 1'b0, 1'b0};
    vecs[1]  = '{28'h0003FF0, 11'd2047, 1'b0, 1'b0, 11'd2047, 1'b0, 1'b0};
    vecs[2]  = '{28'h0004000, 11'd2047, 1'b1, 1'b0, 11'd2047, 1'b1, 1'b0};
    vecs[3]  = '{28'hFFFC000, 11'd0,    1'b0, 1'b0, 11'd0,    1'b0, 1'b0};
    vecs[4]  = '{28'hFFF8000, 11'd0,    1'b0, 1'b1, 11'd0,    1'b0, 1'b1};
    vecs[5]  = '{28'h0000008, 11'd1024, 1'b0, 1'b0, 11'd1025, 1'b0, 1'b0};
    vecs[6]  = '{28'h0003FF8, 11'd2047, 1'b0, 1'b0, 11'd2047, 1'b1, 1'b0};
    vecs[7]  = '{28'hFFFFFF7, 11'd1023, 1'b0, 1'b0, 11'd1023, 1'b0, 1'b0};
    vecs[8]  = '{28'h0001230, 11'd1315, 1'b0, 1'b0, 11'd1315, 1'b0, 1'b0};
    vecs[9]  = '{28'hFFFFFF0, 11'd1023, 1'b0, 1'b0, 11'd1023, 1'b0, 1'b0};
    vecs[10] = '{28'h7FFFFFF, 11'd2047, 1'b1, 1'b0, 11'd2047, 1'b1, 1'b0};
    vecs[11] = '{28'h8000000, 11'd0,    1'b0, 1'b1, 11'd0,    1'b0, 1'b1};
    vecs[12] = '{28'h0003FF7, 11'd2047, 1'b0, 1'b0, 11'd2047, 1'b0, 1'b0};
    vecs[13] = '{28'hFFFBFFF, 11'd0,    1'b0, 1'b1, 11'd0,    1'b0, 1'b0};

    // Clock/reset
    reset = 1'b1; CS = 1'b0; enable = 1'b1; clr_sat = 1'b0; Dato_In = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", 0, t_dout, 1024);
    check("rst_dout_r", 0, r_dout, 1024);
    check("rst_dv", 0, t_dv, 0);
    check("rst_flags", 0, {t_pos, t_neg}, 0);
    check("rst_satcnt", 0, t_cnt, 0);
    check("rst_pwm", 0, t_pwm, 0);
    check("rst_ps", 0, t_ps, 0);
    reset = 1'b0;

    // Table: conversion of both instances plus capture latency
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      Dato_In = vecs[v].din;
      CS = 1'b1;
      @(posedge clk);
      #1 CS = 1'b0;
      lat = 0; found = 0;
      for (int i = 1; i <= 6 && found == 0; i++) begin
        @(posedge clk);
        #1;
        if (t_dv) begin found = 1; lat = i; end
      end
      check("latency", v, lat, 2);
      check("r_dv", v, r_dv, 1);
      check("t_code", v, t_dout, vecs[v].t_code);
      check("t_flags", v, {t_pos, t_neg}, {vecs[v].t_p, vecs[v].t_n});
      check("r_code", v, r_dout, vecs[v].r_code);
      check("r_flags", v, {r_pos, r_neg}, {vecs[v].r_p, vecs[v].r_n});
      @(posedge clk);
      #1;
      check("dv_pulse", v, t_dv, 0);
    end
    @(negedge clk);
    check("t_satcnt_tbl", 0, t_cnt, 5);
    check("r_satcnt_tbl", 0, r_cnt, 5);

    // Saturating statistics counter
    @(negedge clk); clr_sat = 1'b1;
    @(negedge clk); clr_sat = 1'b0;
    check("satcnt_clr", 0, t_cnt, 0);
    Dato_In = 28'h0004000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); CS = 1'b1;
      @(negedge clk); CS = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("satcnt_stick", 0, t_cnt, 255);
    check("satcnt_stick_r", 0, r_cnt, 255);
    @(negedge clk); CS = 1'b1;
    @(negedge clk); CS = 1'b0;
    @(negedge clk); clr_sat = 1'b1;
    @(posedge clk);
    #1;
    check("clr_clip_dv", 0, t_dv, 1);
    check("clr_clip_cnt", 0, t_cnt, 0);
    @(negedge clk); clr_sat = 1'b0;
    drive_sample(28'h0004000);
    check("satcnt_after_clr", 0, t_cnt, 1);

    // Mid-period duty change: 1024 this period, 512 the next
    drive_sample(28'h0000000);
    wait_ps(cyc);
    wait_ps(cyc);
    hi1 = 0; hi2 = 0; bad1 = 0; bad2 = 0; ps_bad = 0;
    fork
      begin
        for (int i = 0; i < 4094; i++) begin
          if (i < 2047) begin
            if (t_pwm) hi1++;
            if (t_pwm != (i < 1024)) bad1++;
          end else begin
            if (t_pwm) hi2++;
            if (t_pwm != ((i - 2047) < 512)) bad2++;
          end
          if (t_ps && i != 0 && i != 2047) ps_bad++;
          if (i == 2047 && !t_ps) ps_bad++;
          @(negedge clk);
        end
      end
      begin
        repeat (300) @(negedge clk);
        Dato_In = 28'hFFFE000;
        CS = 1'b1;
        @(negedge clk);
        CS = 1'b0;
      end
    join
    check("dout_512", 0, t_dout, 512);
    check("p1_high", 0, hi1, 1024);
    check("p1_shape", 0, bad1, 0);
    check("p2_high", 0, hi2, 512);
    check("p2_shape", 0, bad2, 0);
    check("ps_place", 0, ps_bad, 0);

    // Extreme duties over three periods
    drive_sample(28'h8000000);
    wait_ps(cyc);
    wait_ps(cyc);
    measure(6141, hi, starts, bad);
    check("duty0_high", 0, hi, 0);
    check("duty0_starts", 0, starts, 3);
    check("duty0_gap", 0, bad, 0);
    drive_sample(28'h7FFFFFF);
    wait_ps(cyc);
    wait_ps(cyc);
    measure(6141, hi, starts, bad);
    check("duty_full_high", 0, hi, 6141);
    check("duty_full_starts", 0, starts, 3);
    check("duty_full_gap", 0, bad, 0);

    // Enable handling
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check("dis_pwm", 0, t_pwm, 0);
    check("dis_ps", 0, t_ps, 0);
    drive_sample(28'h0000000);
    check("dis_pwm_hold", 0, t_pwm, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_ps", 0, t_ps, 1);
    check("en_pwm", 0, t_pwm, 1);
    measure(2047, hi, starts, bad);
    check("en_high", 0, hi, 1024);
    check("en_starts", 0, starts, 1);

    // Reset mid-period with a half-captured sample
    drive_sample(28'h0001230);
    wait_ps(cyc);
    wait_ps(cyc);
    repeat (898) @(negedge clk);
    Dato_In = 28'h0004000;
    CS = 1'b1;
    @(negedge clk);
    CS = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_dout", 0, t_dout, 1024);
    check("mid_rst_pwm", 0, t_pwm, 0);
    check("mid_rst_ps", 0, t_ps, 0);
    check("mid_rst_cnt", 0, t_cnt, 0);
    check("mid_rst_flags", 0, {t_pos, t_neg}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("restart_ps", 0, t_ps, 1);
    check("restart_pwm", 0, t_pwm, 1);
    dv_sum = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (t_dv) dv_sum++;
    end
    check("discard_dv", 0, dv_sum, 0);
    check("discard_dout", 0, t_dout, 1024);
    wait_ps(cyc);
    check("restart_period", 0, cyc, 2041);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
